// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle. The master drives vld/data and the slave drives rdy.
interface stream_fifo_if #(
  parameter int DW = 32
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] data;

  modport master (output vld, output data, input rdy);
  modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with synchronous flush, for decoupling
// a producer from a downstream pipeline stage.
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  stream_fifo_if.slave  src,
  stream_fifo_if.master dst,
  output logic [AW:0]   count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // The extra MSB on each pointer separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign src.rdy  = ~full & ~flush;
  assign dst.vld  = ~empty & ~flush;
  assign push     = src.vld & src.rdy;
  assign pop      = dst.vld & dst.rdy;
  assign dst.data = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= src.data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and random bench for stream_fifo (DW=8, DEPTH=4). A reference queue holds
// the expected beats, and an independent monitor pops and compares them on each output transfer.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  stream_fifo_if #(.DW(8)) s_if ();
  stream_fifo_if #(.DW(8)) d_if ();

  stream_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .src   (s_if),
    .dst   (d_if),
    .count (count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic f, input logic rs);
    @(negedge clk);
    s_if.vld  = v;
    s_if.data = d;
    d_if.rdy  = r;
    flush     = f;
    rst       = rs;
  endtask

  // Reference model: expected handshake outputs from queue occupancy, then queue update.
  initial begin
    int         sz;
    logic       will_push;
    logic       clr;
    logic [7:0] pd;
    forever begin
      @(negedge clk);
      #1;
      sz = exp_q.size();
      chk("src_rdy", {31'd0, s_if.rdy}, {31'd0, (sz < 4) && !flush});
      chk("dst_vld", {31'd0, d_if.vld}, {31'd0, (sz > 0) && !flush});
      chk("count", {29'd0, count}, sz);
      will_push = s_if.vld && (sz < 4) && !flush && !rst;
      clr       = rst || flush;
      pd        = s_if.data;
      #2;
      if (clr) exp_q.delete();
      else if (will_push) exp_q.push_back(pd);
    end
  end

  // Monitor: every completed output transfer must match the oldest expected beat.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && d_if.vld && d_if.rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_empty: got %0h expected no transfer at %0t", d_if.data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("data", {24'd0, d_if.data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v;
    logic [7:0] d;
    logic       last_rdy;
    s_if.vld  = 1'b0;
    s_if.data = 8'h00;
    d_if.rdy  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("reset_count", {29'd0, count}, 0);
    chk("reset_src_rdy", {31'd0, s_if.rdy}, 1);

    // Basic first-word-fall-through
    step(1, 8'h11, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("fwft_vld", {31'd0, d_if.vld}, 1);
    chk("fwft_data", {24'd0, d_if.data}, 32'h11);
    chk("fwft_count", {29'd0, count}, 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("fwft_empty_vld", {31'd0, d_if.vld}, 0);
    chk("fwft_empty_count", {29'd0, count}, 0);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hA4, 0, 0, 0);
      #1;
      chk("full_count", {29'd0, count}, 4);
      chk("full_src_rdy", {31'd0, s_if.rdy}, 0);
    end
    step(1, 8'hA4, 1, 0, 0);
    #1;
    chk("full_head", {24'd0, d_if.data}, 32'hA0);
    step(1, 8'hA4, 0, 0, 0);
    #1;
    chk("retry_src_rdy", {31'd0, s_if.rdy}, 1);
    chk("retry_count", {29'd0, count}, 3);
    step(1, 8'hB0, 1, 0, 0);
    #1;
    chk("refill_count", {29'd0, count}, 4);
    chk("refill_head", {24'd0, d_if.data}, 32'hA1);
    chk("full_pop_src_rdy", {31'd0, s_if.rdy}, 0);

    // Full with dst_rdy: pop only, no same-cycle push
    step(1, 8'hB0, 0, 0, 0);
    #1;
    chk("full_pop_count", {29'd0, count}, 3);
    chk("full_pop_rdy_next", {31'd0, s_if.rdy}, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("drained_count", {29'd0, count}, 0);

    // Streaming across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 1, 0, 0);
      #1;
      if (i > 0) begin
        chk("stream_count", {29'd0, count}, 1);
        chk("stream_data", {24'd0, d_if.data}, i - 1);
      end
    end
    step(0, 8'h00, 1, 0, 0);

    // Random stress; the producer holds a beat until it is taken
    last_rdy = 1'b1;
    v        = 1'b0;
    d        = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      if (!(v && !last_rdy)) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      step(v, d, 1'($urandom_range(0, 1)), 0, 0);
      #1;
      last_rdy = s_if.rdy;
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);

    // Flush with both sides requesting
    step(1, 8'hC0, 0, 0, 0);
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 0, 0, 0);
    step(1, 8'hC3, 1, 1, 0);
    #1;
    chk("flush_count_before", {29'd0, count}, 3);
    chk("flush_src_rdy", {31'd0, s_if.rdy}, 0);
    chk("flush_dst_vld", {31'd0, d_if.vld}, 0);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("flush_count", {29'd0, count}, 0);
    chk("flush_vld_after", {31'd0, d_if.vld}, 0);
    chk("flush_rdy_after", {31'd0, s_if.rdy}, 1);

    // Reset mid-stream
    step(1, 8'hD0, 0, 0, 0);
    step(1, 8'hD1, 0, 0, 0);
    step(1, 8'hD2, 0, 0, 0);
    step(1, 8'hD3, 1, 0, 1);
    #1;
    chk("rst_count_before", {29'd0, count}, 3);
    step(1, 8'hE0, 0, 0, 0);
    #1;
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_dst_vld", {31'd0, d_if.vld}, 0);
    chk("rst_src_rdy", {31'd0, s_if.rdy}, 1);
    step(0, 8'h00, 0, 0, 0);
    #1;
    chk("post_rst_vld", {31'd0, d_if.vld}, 1);
    chk("post_rst_data", {24'd0, d_if.data}, 32'hE0);
    chk("post_rst_count", {29'd0, count}, 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    #4;
    chk("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous valid/ready FIFO that buffers a data stream between a producer and a downstream pipeline register stage, e.g. fetch to decode.
- Decouples the two sides: src_rdy depends only on occupancy, never on dst_rdy. Unlike a single-entry slice, it absorbs bursts of up to DEPTH beats.
- First-word-fall-through: the head entry is always presented on dst_data while dst_vld=1.
- Includes a synchronous flush for pipeline redirects such as branch mispredicts and exceptions.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 4, number of entries. Must be a power of two, >= 2.
- AW, $clog2(DEPTH), pointer index width. Derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all entries.
- src_vld  input  1  producer has a beat.
- src_rdy  output  1  FIFO accepts a beat this cycle.
- src_data  input  DW  producer data.
- dst_vld  output  1  head entry is valid.
- dst_rdy  input  1  consumer takes the head this cycle.
- dst_data  output  DW  head entry data.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset: synchronous to clk. While rst=1 at a rising edge, wr_ptr=0, rd_ptr=0, count=0. After that edge: dst_vld=0, src_rdy=1, count=0. dst_data is don't-care while dst_vld=0. Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal, wrap bits differ).
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Handshake rules:
  - src_rdy = ~full & ~flush.
  - dst_vld = ~empty & ~flush.
  - push = src_vld & src_rdy; pop = dst_vld & dst_rdy.
  - On push: mem[wr_ptr[AW-1:0]] <= src_data, then wr_ptr increments.
  - On pop: rd_ptr increments.
  - dst_data = mem[rd_ptr[AW-1:0]], combinational read of the registered array.
- Latency:
  - A beat pushed at edge N appears on dst_vld/dst_data in the cycle after edge N.
  - No combinational path from src_* to dst_* or from dst_rdy to src_rdy.
- Ordering: strict FIFO. No beat is dropped or duplicated outside flush.
- Simultaneous push and pop when not full and not empty: both occur and count is unchanged.
- Empty with src_vld=1: the push occurs. There is no same-cycle bypass; dst_vld rises next cycle.
- Full: src_rdy=0 even if dst_rdy=1 in the same cycle. The push is retried next cycle, when src_rdy=1 because the pop freed an entry.
- Wrap-around: index bits roll over from DEPTH-1 to 0 and the wrap bit toggles. Full and empty stay correct across any number of wraps.
- Flush:
  - While flush=1, src_rdy=0 and dst_vld=0, so no handshake completes.
  - At the edge, wr_ptr and rd_ptr are set to 0.
  - Next cycle: count=0, dst_vld=0, src_rdy=1 (unless flush is still held).
- Priority: rst > flush > push/pop.
- Reset mid-operation: all contents are discarded, same as a flush. A transfer whose handshake coincides with rst=1 has no effect.
- Producer rule: src_vld must not drop, and src_data must not change, while src_vld=1 & src_rdy=0.
- Consumer guarantee: dst_data holds stable while dst_vld=1 & dst_rdy=0.

Test Plan:
- Basic FWFT (DW=8, DEPTH=4): push 0x11 with dst_rdy=0 -> next cycle dst_vld=1, dst_data=0x11, count=1; assert dst_rdy -> dst_vld=0, count=0.
- Fill and backpressure: push 0xA0..0xA3 with dst_rdy=0 -> count=4, src_rdy=0; hold src_vld with 0xA4 for 3 cycles -> not accepted, count stays 4; dst_rdy=1 for 1 cycle -> pops 0xA0, next cycle 0xA4 accepted, count=4.
- Full plus dst_rdy in the same cycle: at count=4 with src_vld=1 and dst_rdy=1 -> pop only, count=3, src_rdy=1 the next cycle. There is no combinational rdy path.
- Streaming and wrap: src_vld=1 and dst_rdy=1 continuously for 20 beats with values 0..19 -> output order 0..19, one beat per cycle after the first, count steady at 1; pointers wrap 5 times with no full/empty error.
- Random stress: random src_vld/dst_rdy at 50% for 1000 cycles against a scoreboard queue -> exact order match; count always equals scoreboard size and never exceeds 4.
- Flush and reset: with count=3, assert flush with src_vld=1 and dst_rdy=1 -> no handshake, next cycle count=0, dst_vld=0, src_rdy=1. Repeat with rst=1 mid-stream -> same result, and the first post-reset push appears one cycle later.
